div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle radix-2 integer divider sequencer that serves the execute stage for DIV/DIVU/REM/REMU.
- Takes operands and a start request from EX, runs a 32-step restoring shift-subtract loop, and returns {remainder, quotient}.
- EX holds start_i and asserts its stall request until ready_o is seen.
- Handles RISC-V divide-by-zero and signed-overflow results without iterating.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- signed_div_i  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by EX until ready_o is seen, then dropped.
- annul_i  in  1  abort (pipeline flush/exception).
- result_o  out  2*DATA_W  [63:32] remainder, [31:0] quotient.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, immediate, any state): state=FREE, ready_o=0, result_o=0, counter=0, internal operand registers cleared.
- States, encoded in defines.v:
  - FREE (00): idle.
  - BYZERO (01): divide-by-zero or signed overflow; one cycle.
  - ON (10): iterating.
  - END (11): result held.
- FREE: on an edge with start_i=1 and annul_i=0:
  - opdata2_i==0 -> BYZERO, capture the zero-divide result.
  - signed_div_i=1 and opdata1_i=0x80000000 and opdata2_i=0xFFFFFFFF -> BYZERO, capture the overflow result.
  - Otherwise -> ON. Latch |dividend| and |divisor| (two's-complement negate when signed and MSB=1; unsigned passes through). Latch the sign flags and signed_div_i. Clear the counter.
  - annul_i=1 has priority: stay in FREE.
- Special results:
  - Zero divide: quotient=0xFFFFFFFF, remainder=dividend, for both signed and unsigned.
  - Overflow: quotient=0x80000000, remainder=0.
- BYZERO: next edge -> END with ready_o=1. Total 2 edges from start.
- ON, each edge:
  - Partial remainder P (33 bits) = {P[31:0], dividend MSB}; shift the dividend left.
  - If P >= divisor: P -= divisor, quotient bit = 1; else quotient bit = 0.
  - counter++.
  - annul_i=1 -> FREE, ready_o=0, result untouched. start_i dropping without annul does not abort.
- ON exit at counter==DATA_W-1 (32nd iteration edge) -> END:
  - Apply signs: quotient negated if signed and the operand signs differ; remainder negated if signed and the dividend was negative (remainder takes the dividend's sign).
  - Register into result_o; ready_o=1.
  - Latency: ready_o high after 33 edges counted from the start-sampling edge; EX stalls 33 cycles.
- END:
  - ready_o=1 and result_o stable while start_i=1.
  - Edge with start_i=0 -> FREE, ready_o=0; result_o keeps its last value.
  - annul_i=1 -> FREE, ready_o=0.
- The operand inputs are ignored outside the FREE-exit edge; changes during ON do not affect the result.
- Back-to-back: start_i must drop for at least one cycle (END->FREE) before the next operation is accepted.
- Width rules: all subtracts are unsigned on 33 bits; the counter is clog2(DATA_W)+1 bits wide and never wraps, because it exits at DATA_W-1.

Decomposition:
- defines.v (shared) holds:
  - the state constants DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady/DivResultNotReady, DivStart/DivStop;
  - DoubleRegBus and RegBus widths.
- No sub-module. The step subtractor and sign fix-up are inline combinational logic within a single sequential FSM process.

Test Plan:
- Signed 7 / -2 (0x00000007, 0xFFFFFFFE), start held -> ready_o after 33 edges; result_o[31:0]=0xFFFFFFFD, [63:32]=0x00000001; ready stays high until start drops, then low next edge.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Unsigned 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0x0000000F.
- Divide by zero, 5 / 0, signed and unsigned -> ready after 2 edges; quotient 0xFFFFFFFF, remainder 0x00000005.
- Signed 0x80000000 / 0xFFFFFFFF -> ready after 2 edges; quotient 0x80000000, remainder 0.
- Annul at ON iteration 10 -> FREE next edge, ready_o never asserts; a following start of 100/7 unsigned yields quotient 14, remainder 2 in 33 edges.
- Reset driven low mid-ON (iteration 20), between edges -> ready_o=0 and result_o=0 immediately; after release, state FREE and a new op completes correctly.

Source files
------------

// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared constants for the sequential divider: FSM state encoding, result-ready
// and start/stop levels, and the register/double-register bus widths.
// -----------------------------------------------------------------------------
package div_seq_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    // Divider sequencer states (2-bit encoding shared with the execute stage).
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage : div_seq_pkg

// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Request/response bundle between the execute stage (master) and the divider
// (slave).
//   signed_div_i : 1 = DIV/REM, 0 = DIVU/REMU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held until ready_o is seen
//   annul_i      : abort (flush/exception)
//   result_o     : {remainder, quotient}
//   ready_o      : result valid
// -----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int DATA_W = 32
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface : div_seq_if

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on acceptance, DATA_W shift-subtract
// steps produce the quotient one bit per cycle, and the signs are applied on
// the final step. Divide-by-zero and signed overflow bypass the loop.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : div_seq_if slave modport (operands, start/annul, result/ready)
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic         clk,
    input  logic         rst,
    div_seq_if.slave     bus
);

    localparam int                  CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0]   ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                 input logic              en);
        neg_if = en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_dividend;
    logic [DATA_W-1:0]      r_divisor;
    logic [DATA_W-1:0]      r_part;
    logic [DATA_W-1:0]      r_quot;
    logic                   r_signed;
    logic                   r_neg_a;
    logic                   r_neg_b;
    logic [2*DATA_W-1:0]    r_special;
    logic [2*DATA_W-1:0]    r_result;
    logic                   r_ready;

    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [DATA_W-1:0]      w_abs_a;
    logic [DATA_W-1:0]      w_abs_b;
    logic                   w_zero_div;
    logic                   w_ovf;
    logic [DATA_W:0]        w_p;
    logic [DATA_W:0]        w_p_sub;
    logic                   w_ge;
    logic [DATA_W-1:0]      w_p_next;
    logic [DATA_W-1:0]      w_q_next;
    logic [DATA_W-1:0]      w_q_fix;
    logic [DATA_W-1:0]      w_r_fix;

    // Operand classification and magnitude conversion for the accept edge.
    assign w_a_neg    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign w_b_neg    = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign w_abs_a    = neg_if(bus.opdata1_i, w_a_neg);
    assign w_abs_b    = neg_if(bus.opdata2_i, w_b_neg);
    assign w_zero_div = (bus.opdata2_i == ZERO_W);
    assign w_ovf      = bus.signed_div_i & (bus.opdata1_i == MIN_NEG)
                        & (bus.opdata2_i == ALL_ONES);

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift P < 2*divisor and the borrow bit of the 33-bit
    // subtract alone tells whether P >= divisor.
    assign w_p      = {r_part, r_dividend[DATA_W-1]};
    assign w_p_sub  = w_p - {1'b0, r_divisor};
    assign w_ge     = ~w_p_sub[DATA_W];
    assign w_p_next = w_ge ? w_p_sub[DATA_W-1:0] : w_p[DATA_W-1:0];
    assign w_q_next = {r_quot[DATA_W-2:0], w_ge};

    // Sign fix-up: quotient negative when operand signs differ, remainder
    // follows the dividend (r_neg_* are already gated by the signed flag).
    assign w_q_fix  = neg_if(w_q_next, r_signed & (r_neg_a ^ r_neg_b));
    assign w_r_fix  = neg_if(w_p_next, r_signed & r_neg_a);

    // Divider sequencer: accept, special-case bypass, iterate, hold result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= DivFree;
            r_cnt      <= {CNT_W{1'b0}};
            r_dividend <= ZERO_W;
            r_divisor  <= ZERO_W;
            r_part     <= ZERO_W;
            r_quot     <= ZERO_W;
            r_signed   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_special  <= {(2*DATA_W){1'b0}};
            r_result   <= {(2*DATA_W){1'b0}};
            r_ready    <= DivResultNotReady;
        end else begin
            case (r_state)
                DivFree: begin
                    r_ready <= DivResultNotReady;
                    if ((bus.start_i == DivStart) && !bus.annul_i) begin
                        if (w_zero_div) begin
                            r_special <= {bus.opdata1_i, ALL_ONES};
                            r_state   <= DivByZero;
                        end else if (w_ovf) begin
                            r_special <= {ZERO_W, MIN_NEG};
                            r_state   <= DivByZero;
                        end else begin
                            r_dividend <= w_abs_a;
                            r_divisor  <= w_abs_b;
                            r_neg_a    <= w_a_neg;
                            r_neg_b    <= w_b_neg;
                            r_signed   <= bus.signed_div_i;
                            r_part     <= ZERO_W;
                            r_quot     <= ZERO_W;
                            r_cnt      <= {CNT_W{1'b0}};
                            r_state    <= DivOn;
                        end
                    end else begin
                        r_state <= DivFree;
                    end
                end
                DivByZero: begin
                    r_result <= r_special;
                    r_ready  <= DivResultReady;
                    r_state  <= DivEnd;
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        r_ready <= DivResultNotReady;
                        r_state <= DivFree;
                    end else begin
                        r_part     <= w_p_next;
                        r_quot     <= w_q_next;
                        r_dividend <= {r_dividend[DATA_W-2:0], 1'b0};
                        r_cnt      <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_CNT) begin
                            r_result <= {w_r_fix, w_q_fix};
                            r_ready  <= DivResultReady;
                            r_state  <= DivEnd;
                        end else begin
                            r_state  <= DivOn;
                        end
                    end
                end
                DivEnd: begin
                    if (bus.annul_i || (bus.start_i == DivStop)) begin
                        r_ready <= DivResultNotReady;
                        r_state <= DivFree;
                    end else begin
                        r_ready <= DivResultReady;
                        r_state <= DivEnd;
                    end
                end
                default: begin
                    r_ready <= DivResultNotReady;
                    r_state <= DivFree;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule : div_seq
